conv_ctrl: RTL and testbench

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_pkg.sv | 44 ++++
 rtl/conv_addr_gen.sv | 63 ++++++
 rtl/conv_ctrl.sv | 148 ++++++++++++++
 tb/tb_conv_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, state encoding and counter payload for the 3x3 convolution controller.
package conv_pkg;

  localparam int unsigned IMG_W  = 8;   // image width/height in pixels
  localparam int unsigned KER    = 3;   // kernel width/height
  localparam int unsigned OUT_W  = 6;   // valid output width/height
  localparam int unsigned N_TAP  = 9;   // taps per window
  localparam int unsigned N_OUT  = 36;  // windows per frame
  localparam int unsigned RD_LAT = 1;   // pixel RAM read latency in cycles

  localparam int unsigned ADDR_W = 6;   // pixel RAM address width
  localparam int unsigned TAP_W  = 4;   // tap index width
  localparam int unsigned OIDX_W = 6;   // output index width
  localparam int unsigned RC_W   = 3;   // window row/column counter width
  localparam int unsigned IJ_W   = 2;   // tap row/column counter width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Window position (r,c), tap position (i,j), linear tap and window indices.
  typedef struct packed {
    logic [RC_W-1:0]   r;
    logic [RC_W-1:0]   c;
    logic [IJ_W-1:0]   i;
    logic [IJ_W-1:0]   j;
    logic [TAP_W-1:0]  tap;
    logic [OIDX_W-1:0] win;
  } cnt_t;

  // Pixel address of the tap selected by a counter set: (r+i)*IMG_W + (c+j).
  function automatic logic [ADDR_W-1:0] tap_addr(input cnt_t k);
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    row = k.r + RC_W'(k.i);
    col = k.c + RC_W'(k.j);
    return ADDR_W'(32'(row) * IMG_W + 32'(col));
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window/tap counters and registered pixel RAM address for the convolution sweep.
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              tap_adv,
  input  logic              win_adv,
  output logic [ADDR_W-1:0] address,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [OIDX_W-1:0] win_idx,
  output logic              last_tap_c,
  output logic              last_win_c
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  // Next counter values: clear wins, window advance restarts the tap walk.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (win_adv) begin
      cnt_d.i   = '0;
      cnt_d.j   = '0;
      cnt_d.tap = '0;
      cnt_d.win = cnt_q.win + OIDX_W'(1);
      if (cnt_q.c == RC_W'(OUT_W - 1)) begin
        cnt_d.c = '0;
        cnt_d.r = cnt_q.r + RC_W'(1);
      end else begin
        cnt_d.c = cnt_q.c + RC_W'(1);
      end
    end else if (tap_adv) begin
      cnt_d.tap = cnt_q.tap + TAP_W'(1);
      if (cnt_q.j == IJ_W'(KER - 1)) begin
        cnt_d.j = '0;
        cnt_d.i = cnt_q.i + IJ_W'(1);
      end else begin
        cnt_d.j = cnt_q.j + IJ_W'(1);
      end
    end
  end

  // Counter state and address register; address always tracks the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      address <= '0;
    end else begin
      cnt_q   <= cnt_d;
      address <= tap_addr(cnt_d);
    end
  end

  assign tap_idx    = cnt_q.tap;
  assign win_idx    = cnt_q.win;
  assign last_tap_c = (cnt_q.tap == TAP_W'(N_TAP - 1));
  assign last_win_c = (cnt_q.win == OIDX_W'(N_OUT - 1));

endmodule

// File: rtl/conv_ctrl.sv
// Sequencer for a 3x3 convolution over an 8x8 frame held in an external pixel RAM.
module conv_ctrl
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_st,
  input  logic              abort,
  input  logic              out_rdy,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] address,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [TAP_W-1:0]  k_idx,
  output logic              out_st,
  output logic [OIDX_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  state_t state_q;
  state_t state_d;

  logic              tap_adv;
  logic              win_adv;
  logic              cnt_clr;
  logic              kill;
  logic [TAP_W-1:0]  tap_idx;
  logic [OIDX_W-1:0] win_idx;
  logic              last_tap_c;
  logic              last_win_c;

  // Read strobe, first-tap flag and tap index delayed by the RAM latency.
  logic [RD_LAT-1:0]            rd_pipe;
  logic [RD_LAT-1:0]            clr_pipe;
  logic [RD_LAT-1:0][TAP_W-1:0] tap_pipe;

  conv_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clr),
    .tap_adv    (tap_adv),
    .win_adv    (win_adv),
    .address    (address),
    .tap_idx    (tap_idx),
    .win_idx    (win_idx),
    .last_tap_c (last_tap_c),
    .last_win_c (last_win_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter steering; abort beats out_rdy in every busy state.
  always_comb begin
    state_d = state_q;
    tap_adv = 1'b0;
    win_adv = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_st) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_tap_c) begin
          state_d = ST_WAIT;
        end else begin
          tap_adv = 1'b1;
        end
      end
      ST_WAIT: begin
        state_d = abort ? ST_IDLE : ST_EMIT;
      end
      ST_EMIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (out_rdy) begin
          if (last_win_c) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            win_adv = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Returning to IDLE rewinds the counters and flushes reads in flight.
  assign cnt_clr = (state_d == ST_IDLE);
  assign kill    = (state_d == ST_IDLE);

  // Strobes registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd  <= 1'b0;
      out_st  <= 1'b0;
      out_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ram_rd <= (state_d == ST_FETCH);
      out_st <= (state_d == ST_EMIT);
      busy   <= (state_d inside {ST_FETCH, ST_WAIT, ST_EMIT});
      done   <= (state_d == ST_DONE);
      if (state_d == ST_EMIT) out_idx <= win_idx;
    end
  end

  // RAM latency pipeline feeding the MAC controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe  <= '0;
      clr_pipe <= '0;
      tap_pipe <= '0;
    end else if (kill) begin
      rd_pipe  <= '0;
      clr_pipe <= '0;
    end else begin
      rd_pipe[0]  <= ram_rd;
      clr_pipe[0] <= ram_rd && (tap_idx == '0);
      if (ram_rd) tap_pipe[0] <= tap_idx;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        rd_pipe[s]  <= rd_pipe[s-1];
        clr_pipe[s] <= clr_pipe[s-1];
        tap_pipe[s] <= tap_pipe[s-1];
      end
    end
  end

  assign mac_en  = rd_pipe[RD_LAT-1];
  assign mac_clr = clr_pipe[RD_LAT-1];
  assign k_idx   = tap_pipe[RD_LAT-1];

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed self-checking bench for conv_ctrl.
module tb_conv_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_st;
  logic       abort;
  logic       out_rdy;
  logic       ram_rd;
  logic [5:0] address;
  logic       mac_en;
  logic       mac_clr;
  logic [3:0] k_idx;
  logic       out_st;
  logic [5:0] out_idx;
  logic       busy;
  logic       done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int w0_tab  [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  int w35_tab [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

  conv_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_st   (in_st),
    .abort   (abort),
    .out_rdy (out_rdy),
    .ram_rd  (ram_rd),
    .address (address),
    .mac_en  (mac_en),
    .mac_clr (mac_clr),
    .k_idx   (k_idx),
    .out_st  (out_st),
    .out_idx (out_idx),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs at cycle n after the in_st sample, out_rdy high throughout.
  // ctl = {ram_rd, mac_en, mac_clr, out_st, busy, done}
  task automatic model(input int n, output logic [5:0] ctl, output logic [5:0] ea,
                       output logic [3:0] ek, output logic [5:0] eo);
    int w, p, r, c, i, j;
    ctl = '0; ea = '0; ek = '0; eo = '0;
    if (n >= 1 && n <= 396) begin
      w = (n - 1) / 11;
      p = (n - 1) % 11;
      r = w / 6;  c = w % 6;
      i = p / 3;  j = p % 3;
      ctl[5] = (p < 9);
      ctl[4] = (p >= 1 && p <= 9);
      ctl[3] = (p == 1);
      ctl[2] = (p == 10);
      ctl[1] = 1'b1;
      ea = 6'((r + i) * 8 + c + j);
      ek = 4'(p - 1);
      eo = 6'(w);
    end else if (n == 397) begin
      ctl[0] = 1'b1;
    end
  endtask

  // One frame with an optional EMIT stall on window stall_win and optional in_st noise.
  task automatic run_frame(input string name, input int stall_win, input int stall_len,
                           input bit poke);
    logic [5:0] ectl, actl, ea, eo;
    logic [3:0] ek;
    int e, ne;
    e = 11 * (stall_win + 1);
    in_st = 1'b1; out_rdy = 1'b1;
    step();
    in_st = 1'b0;
    for (int n = 1; n <= 398 + stall_len; n++) begin
      if (n <= e) ne = n;
      else if (n <= e + stall_len) ne = e;
      else ne = n - stall_len;
      out_rdy = !(stall_len > 0 && n >= e && n < e + stall_len);
      in_st = poke && (ne >= 2) && (ne <= 396) && ((n % 3) == 1);
      model(ne, ectl, ea, ek, eo);
      actl = {ram_rd, mac_en, mac_clr, out_st, busy, done};
      chk_cnt++;
      if (actl !== ectl) $display("FAIL %s ctl cyc=%0d got=%b exp=%b", name, n, actl, ectl);
      else pass_cnt++;
      if (ectl[5]) begin
        chk_cnt++;
        if (address !== ea) $display("FAIL %s address cyc=%0d got=%0d exp=%0d", name, n, address, ea);
        else pass_cnt++;
      end
      if (ectl[4]) begin
        chk_cnt++;
        if (k_idx !== ek) $display("FAIL %s k_idx cyc=%0d got=%0d exp=%0d", name, n, k_idx, ek);
        else pass_cnt++;
      end
      if (ectl[2]) begin
        chk_cnt++;
        if (out_idx !== eo) $display("FAIL %s out_idx cyc=%0d got=%0d exp=%0d", name, n, out_idx, eo);
        else pass_cnt++;
      end
      if (ne >= 1 && ne <= 9 && n == ne) begin
        chk_cnt++;
        if (address !== 6'(w0_tab[ne-1]))
          $display("FAIL %s win0_addr cyc=%0d got=%0d exp=%0d", name, n, address, w0_tab[ne-1]);
        else pass_cnt++;
      end
      if (ne >= 386 && ne <= 394) begin
        chk_cnt++;
        if (address !== 6'(w35_tab[ne-386]))
          $display("FAIL %s win35_addr cyc=%0d got=%0d exp=%0d", name, n, address, w35_tab[ne-386]);
        else pass_cnt++;
      end
      step();
    end
    in_st = 1'b0; out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    in_st = 1'b0; abort = 1'b0; out_rdy = 1'b1; rst_n = 1'b0;
    #12;
    chk_cnt++;
    if ({ram_rd, address, mac_en, mac_clr, k_idx, out_st, out_idx, busy, done} !== '0)
      $display("FAIL reset_outputs got=%b exp=0",
               {ram_rd, address, mac_en, mac_clr, k_idx, out_st, out_idx, busy, done});
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    step(); step();
    chk_cnt++;
    if ({ram_rd, mac_en, out_st, busy, done} !== 5'b0)
      $display("FAIL idle_after_reset got=%b exp=00000", {ram_rd, mac_en, out_st, busy, done});
    else pass_cnt++;
  endtask

  task automatic test_full_frame();
    run_frame("full", 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_frame("stall", 7, 5, 1'b0);
  endtask

  task automatic test_abort();
    int done_seen;
    in_st = 1'b1; out_rdy = 1'b1;
    step();
    in_st = 1'b0;
    for (int n = 1; n < 135; n++) step();
    chk_cnt++;
    if ({ram_rd, address} !== {1'b1, 6'd18})
      $display("FAIL abort_pre rd/addr got=%b/%0d exp=1/18", ram_rd, address);
    else pass_cnt++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_cnt++;
    if ({ram_rd, mac_en, out_st, busy, done} !== 5'b0)
      $display("FAIL abort_idle got=%b exp=00000", {ram_rd, mac_en, out_st, busy, done});
    else pass_cnt++;
    done_seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (done || busy || ram_rd || mac_en || out_st) done_seen++;
      step();
    end
    chk_cnt++;
    if (done_seen !== 0) $display("FAIL abort_quiet active_cycles got=%0d exp=0", done_seen);
    else pass_cnt++;
    in_st = 1'b1;
    step();
    in_st = 1'b0;
    chk_cnt++;
    if ({ram_rd, address} !== {1'b1, 6'd0})
      $display("FAIL abort_restart rd/addr got=%b/%0d exp=1/0", ram_rd, address);
    else pass_cnt++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    in_st = 1'b1;
    step();
    in_st = 1'b0;
    for (int n = 1; n < 10; n++) step();
    chk_cnt++;
    if ({ram_rd, mac_en, k_idx, address} !== {1'b0, 1'b1, 4'd8, 6'd18})
      $display("FAIL wait_state rd/mac/k/addr got=%b/%b/%0d/%0d exp=0/1/8/18",
               ram_rd, mac_en, k_idx, address);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({ram_rd, address, mac_en, mac_clr, k_idx, out_st, out_idx, busy, done} !== '0)
      $display("FAIL reset_mid_wait got=%b exp=0",
               {ram_rd, address, mac_en, mac_clr, k_idx, out_st, out_idx, busy, done});
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_in_st_ignored();
    run_frame("in_st_busy", 0, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_abort();
    test_reset_mid_wait();
    test_in_st_ignored();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
